// File: rtl/test_pe_pkg.sv
// Shared types for the PE pipeline: opcodes, flag selects, operand modes, config map.
// Combinational constants only; no timing or flow-control behaviour.
package test_pe_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_MUL    = 4'd2,
    OP_AND    = 4'd3,
    OP_OR     = 4'd4,
    OP_XOR    = 4'd5,
    OP_MAX    = 4'd6,
    OP_MIN    = 4'd7,
    OP_SEL    = 4'd8,
    OP_PASS_A = 4'd9
  } op_e;

  typedef enum logic [3:0] {
    FS_Z   = 4'h0,
    FS_NZ  = 4'h1,
    FS_C   = 4'h2,
    FS_NC  = 4'h3,
    FS_N   = 4'h4,
    FS_NN  = 4'h5,
    FS_V   = 4'h6,
    FS_NV  = 4'h7,
    FS_HI  = 4'h8,
    FS_LS  = 4'h9,
    FS_GE  = 4'hA,
    FS_LT  = 4'hB,
    FS_GT  = 4'hC,
    FS_LE  = 4'hD,
    FS_D0  = 4'hE,
    FS_D1  = 4'hF
  } flag_sel_e;

  typedef enum logic [1:0] {
    MODE_BYP   = 2'd0,
    MODE_REG   = 2'd1,
    MODE_CONST = 2'd2,
    MODE_BYP2  = 2'd3
  } mode_e;

  localparam logic [7:0] ADDR_DBG     = 8'hE0;
  localparam logic [7:0] ADDR_A       = 8'hF0;
  localparam logic [7:0] ADDR_B       = 8'hF1;
  localparam logic [7:0] ADDR_D       = 8'hF3;
  localparam logic [7:0] ADDR_ACC_LEN = 8'hF8;
  localparam logic [7:0] ADDR_ACC     = 8'hF9;
  localparam logic [7:0] ADDR_CODE    = 8'hFF;

endpackage

// File: rtl/test_pe_pipe_opt_reg.sv
// Operand source: bypass, clk_en-captured register, or config constant (same register).
// Zero latency in bypass/const modes, one clk_en cycle in registered mode; no backpressure.
module test_opt_reg_p
  import test_pe_pkg::*;
#(
  parameter int DataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic [1:0]           mode_i,
  input  logic                 cfg_we_i,
  input  logic [DataWidth-1:0] cfg_dat_i,
  input  logic [DataWidth-1:0] data_i,
  output logic [DataWidth-1:0] data_o,
  output logic [DataWidth-1:0] reg_o
);

  logic [DataWidth-1:0] reg_q, reg_d;

  // Config write has priority over datapath capture.
  always_comb begin
    reg_d = reg_q;
    if (cfg_we_i) begin
      reg_d = cfg_dat_i;
    end else if (clk_en && (mode_i == MODE_REG)) begin
      reg_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_q <= '0;
    end else begin
      reg_q <= reg_d;
    end
  end

  always_comb begin
    case (mode_i)
      MODE_REG, MODE_CONST: data_o = reg_q;
      default:              data_o = data_i;
    endcase
  end

  assign reg_o = reg_q;

endmodule

// File: rtl/test_pe_pipe.sv
// Configurable PE: operand muxing, ALU with flags, saturating accumulator, clk_en-gated output pipe.
// PipeDepth clk_en cycles of latency; no backpressure, clk_en stalls the whole datapath.
module test_pe_pipe
  import test_pe_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int PipeDepth = 1,
  parameter int CntWidth  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clk_en,
  input  logic [31:0]          cfg_d,
  input  logic [7:0]           cfg_a,
  input  logic                 cfg_en,
  input  logic [DataWidth-1:0] data0,
  input  logic [DataWidth-1:0] data1,
  input  logic                 bit0,
  output logic [DataWidth-1:0] res,
  output logic                 res_p,
  output logic                 res_valid,
  output logic                 irq,
  output logic [31:0]          read_data
);

  localparam int W = DataWidth;
  localparam logic [W:0]          One1   = (W+1)'(1);
  localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);
  localparam logic [W-1:0]        SMax   = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]        SMin   = {1'b1, {(W-1){1'b0}}};

  logic [15:0]          inp_code_q, op_code_q;
  logic [CntWidth-1:0]  acc_len_q, acc_cnt_q, acc_cnt_d;
  logic [W-1:0]         dbg_val_q, acc_q, acc_d;
  logic                 irq_data_q, irq_data_d, irq_bit_q, irq_bit_d;

  logic wr_code, wr_len, wr_dbg, wr_a, wr_b, wr_d, clr_acc;
  assign wr_code = cfg_en && (cfg_a == ADDR_CODE);
  assign wr_len  = cfg_en && (cfg_a == ADDR_ACC_LEN);
  assign wr_dbg  = cfg_en && (cfg_a == ADDR_DBG);
  assign wr_a    = cfg_en && (cfg_a == ADDR_A);
  assign wr_b    = cfg_en && (cfg_a == ADDR_B);
  assign wr_d    = cfg_en && (cfg_a == ADDR_D);
  assign clr_acc = wr_code || wr_len;

  logic [W-1:0] op_a, op_b, reg_a, reg_b;
  logic         op_d, reg_d_bit;

  test_opt_reg_p #(.DataWidth(W)) u_reg_a (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .mode_i(inp_code_q[1:0]),
    .cfg_we_i(wr_a), .cfg_dat_i(cfg_d[W-1:0]), .data_i(data0), .data_o(op_a), .reg_o(reg_a)
  );
  test_opt_reg_p #(.DataWidth(W)) u_reg_b (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .mode_i(inp_code_q[3:2]),
    .cfg_we_i(wr_b), .cfg_dat_i(cfg_d[W-1:0]), .data_i(data1), .data_o(op_b), .reg_o(reg_b)
  );
  test_opt_reg_p #(.DataWidth(1)) u_reg_d (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .mode_i(inp_code_q[5:4]),
    .cfg_we_i(wr_d), .cfg_dat_i(cfg_d[0]), .data_i(bit0), .data_o(op_d), .reg_o(reg_d_bit)
  );

  // ALU
  logic         sgn, acc_mode, a_gt_b, c_flag, v_flag, z_flag, n_flag, stg_p;
  logic [W:0]   add_full, sub_full;
  logic [W-1:0] mul_lo, comp;

  assign sgn      = op_code_q[4];
  assign acc_mode = op_code_q[9];
  assign add_full = {1'b0, op_a} + {1'b0, op_b};
  assign sub_full = {1'b0, op_a} + {1'b0, ~op_b} + One1;
  assign mul_lo   = op_a * op_b;
  assign a_gt_b   = sgn ? ($signed(op_a) > $signed(op_b)) : (op_a > op_b);

  always_comb begin
    comp   = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (op_code_q[3:0])
      OP_ADD: begin
        comp   = add_full[W-1:0];
        c_flag = add_full[W];
        v_flag = sgn && (op_a[W-1] == op_b[W-1]) && (add_full[W-1] != op_a[W-1]);
      end
      OP_SUB: begin
        comp   = sub_full[W-1:0];
        c_flag = sub_full[W];
        v_flag = sgn && (op_a[W-1] != op_b[W-1]) && (sub_full[W-1] != op_a[W-1]);
      end
      OP_MUL:    comp = mul_lo;
      OP_AND:    comp = op_a & op_b;
      OP_OR:     comp = op_a | op_b;
      OP_XOR:    comp = op_a ^ op_b;
      OP_MAX:    comp = a_gt_b ? op_a : op_b;
      OP_MIN:    comp = a_gt_b ? op_b : op_a;
      OP_SEL:    comp = op_d ? op_a : op_b;
      OP_PASS_A: comp = op_a;
      default:   comp = '0;
    endcase
  end

  assign z_flag = (comp == '0);
  assign n_flag = comp[W-1];

  always_comb begin
    case (op_code_q[15:12])
      FS_Z:    stg_p = z_flag;
      FS_NZ:   stg_p = !z_flag;
      FS_C:    stg_p = c_flag;
      FS_NC:   stg_p = !c_flag;
      FS_N:    stg_p = n_flag;
      FS_NN:   stg_p = !n_flag;
      FS_V:    stg_p = v_flag;
      FS_NV:   stg_p = !v_flag;
      FS_HI:   stg_p = c_flag && !z_flag;
      FS_LS:   stg_p = !c_flag || z_flag;
      FS_GE:   stg_p = (n_flag == v_flag);
      FS_LT:   stg_p = (n_flag != v_flag);
      FS_GT:   stg_p = !z_flag && (n_flag == v_flag);
      FS_LE:   stg_p = z_flag || (n_flag != v_flag);
      default: stg_p = op_d;
    endcase
  end

  // Accumulator with saturation; D=1 restarts the running sum from zero.
  logic [W:0]   acc_sum;
  logic [W-1:0] acc_sat, acc_next, stg_val;
  logic         acc_ovf, acc_last, stg_vld;

  assign acc_sum  = {1'b0, acc_q} + {1'b0, comp};
  assign acc_ovf  = (acc_q[W-1] == comp[W-1]) && (acc_sum[W-1] != acc_q[W-1]);
  assign acc_sat  = sgn ? (acc_ovf ? (acc_q[W-1] ? SMin : SMax) : acc_sum[W-1:0])
                        : (acc_sum[W] ? {W{1'b1}} : acc_sum[W-1:0]);
  assign acc_next = op_d ? '0 : acc_sat;
  assign acc_last = (acc_len_q != '0) && (acc_cnt_q == acc_len_q - CntOne);

  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    stg_val   = comp;
    stg_vld   = 1'b1;
    if (acc_mode) begin
      stg_val = acc_next;
      stg_vld = (acc_len_q == '0) || acc_last;
    end
    if (clr_acc) begin
      acc_d     = '0;
      acc_cnt_d = '0;
    end else if (clk_en && acc_mode) begin
      if (acc_last) begin
        acc_d     = '0;
        acc_cnt_d = '0;
      end else begin
        acc_d     = acc_next;
        acc_cnt_d = acc_cnt_q + CntOne;
      end
    end
  end

  // Output pipeline
  logic last_vld;

  generate
    if (PipeDepth == 0) begin : g_comb
      assign res      = stg_val;
      assign res_p    = stg_p;
      assign last_vld = stg_vld;
    end else begin : g_pipe
      logic [W-1:0] val_q [PipeDepth];
      logic         p_q   [PipeDepth];
      logic         vld_q [PipeDepth];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < PipeDepth; i++) begin
            val_q[i] <= '0;
            p_q[i]   <= 1'b0;
            vld_q[i] <= 1'b0;
          end
        end else if (clr_acc) begin
          for (int i = 0; i < PipeDepth; i++) vld_q[i] <= 1'b0;
        end else if (clk_en) begin
          val_q[0] <= stg_val;
          p_q[0]   <= stg_p;
          vld_q[0] <= stg_vld;
          for (int i = 1; i < PipeDepth; i++) begin
            val_q[i] <= val_q[i-1];
            p_q[i]   <= p_q[i-1];
            vld_q[i] <= vld_q[i-1];
          end
        end
      end

      assign res      = val_q[PipeDepth-1];
      assign res_p    = p_q[PipeDepth-1];
      assign last_vld = vld_q[PipeDepth-1];
    end
  endgenerate

  // A clearing config write suppresses the pulse in the cycle it lands.
  assign res_valid = last_vld && clk_en && !clr_acc;

  always_comb begin
    irq_data_d = irq_data_q || (res_valid && (res == dbg_val_q));
    irq_bit_d  = irq_bit_q  || (res_valid && res_p);
    if (wr_dbg) begin
      irq_data_d = 1'b0;
      irq_bit_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inp_code_q <= '0;
      op_code_q  <= '0;
      acc_len_q  <= '0;
      dbg_val_q  <= '0;
      acc_q      <= '0;
      acc_cnt_q  <= '0;
      irq_data_q <= 1'b0;
      irq_bit_q  <= 1'b0;
    end else begin
      if (wr_code) begin
        inp_code_q <= cfg_d[31:16];
        op_code_q  <= cfg_d[15:0];
      end
      if (wr_len) acc_len_q <= cfg_d[CntWidth-1:0];
      if (wr_dbg) dbg_val_q <= cfg_d[W-1:0];
      acc_q      <= acc_d;
      acc_cnt_q  <= acc_cnt_d;
      irq_data_q <= irq_data_d;
      irq_bit_q  <= irq_bit_d;
    end
  end

  assign irq = |({irq_data_q, irq_bit_q} & op_code_q[11:10]);

  always_comb begin
    case (cfg_a)
      ADDR_DBG:     read_data = 32'({irq_bit_q, irq_data_q, dbg_val_q});
      ADDR_A:       read_data = 32'(reg_a);
      ADDR_B:       read_data = 32'(reg_b);
      ADDR_D:       read_data = 32'(reg_d_bit);
      ADDR_ACC_LEN: read_data = 32'({acc_cnt_q, acc_len_q});
      ADDR_ACC:     read_data = 32'(acc_q);
      ADDR_CODE:    read_data = {inp_code_q, op_code_q};
      default:      read_data = '0;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{inp_code_q[15:6], op_code_q[8:5]};

endmodule

// File: tb/tb_test_pe_pipe.sv
// Bench for test_pe_pipe: directed vector table, randomized ALU check against an integer model,
// and hand-written sequences for accumulation, saturation, irq, stall, clear and async reset.
module tb_test_pe_pipe;

  localparam int W = 16;
  localparam longint M = 64'd1 << W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clk_en = 1'b0;
  logic [31:0]   cfg_d = '0;
  logic [7:0]    cfg_a = '0;
  logic          cfg_en = 1'b0;
  logic [W-1:0]  data0 = '0, data1 = '0;
  logic          bit0 = 1'b0;
  logic [W-1:0]  res;
  logic          res_p, res_valid, irq;
  logic [31:0]   read_data;

  int checks = 0;
  int failures = 0;

  test_pe_pipe #(.DataWidth(W), .PipeDepth(1), .CntWidth(8)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .cfg_d(cfg_d), .cfg_a(cfg_a),
    .cfg_en(cfg_en), .data0(data0), .data1(data1), .bit0(bit0), .res(res),
    .res_p(res_p), .res_valid(res_valid), .irq(irq), .read_data(read_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
    cfg_en = 1'b1;
    cfg_a  = a;
    cfg_d  = d;
    tick();
    cfg_en = 1'b0;
    cfg_a  = 8'h00;
  endtask

  // Integer-arithmetic reference for a single non-accumulating operation.
  function automatic void ref_alu(input logic [15:0] opc, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic d, output logic [W-1:0] r, output logic p);
    longint ua, ub, sa, sb, full, s;
    logic sg, c, v, z, n;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[W-1] ? ua - M : ua;
    sb = b[W-1] ? ub - M : ub;
    sg = opc[4];
    c = 1'b0;
    v = 1'b0;
    case (opc[3:0])
      4'd0: begin full = ua + ub; c = (full >= M); s = sa + sb; v = sg && (s >= M/2 || s < -(M/2)); end
      4'd1: begin full = ua - ub; c = (ua >= ub); s = sa - sb; v = sg && (s >= M/2 || s < -(M/2)); end
      4'd2: full = ua * ub;
      4'd3: full = ua & ub;
      4'd4: full = ua | ub;
      4'd5: full = ua ^ ub;
      4'd6: full = sg ? ((sa > sb) ? ua : ub) : ((ua > ub) ? ua : ub);
      4'd7: full = sg ? ((sa < sb) ? ua : ub) : ((ua < ub) ? ua : ub);
      4'd8: full = d ? ua : ub;
      4'd9: full = ua;
      default: full = 0;
    endcase
    r = full[W-1:0];
    z = (r == 0);
    n = r[W-1];
    case (opc[15:12])
      4'h0: p = z;
      4'h1: p = !z;
      4'h2: p = c;
      4'h3: p = !c;
      4'h4: p = n;
      4'h5: p = !n;
      4'h6: p = v;
      4'h7: p = !v;
      4'h8: p = c && !z;
      4'h9: p = !c || z;
      4'hA: p = (n == v);
      4'hB: p = (n != v);
      4'hC: p = !z && (n == v);
      4'hD: p = z || (n != v);
      default: p = d;
    endcase
  endfunction

  typedef struct {
    logic [15:0]  op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         d;
    logic [W-1:0] er;
    logic         ep;
  } vec_t;

  vec_t tv[18];

  initial begin
    logic [W-1:0] ra, rb, er;
    logic [15:0]  opc;
    logic         rd, ep;
    int           nv;
    logic [W-1:0] rv;

    tv[0]  = '{16'h6010, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b1};
    tv[1]  = '{16'h2001, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1};
    tv[2]  = '{16'h2001, 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b0};
    tv[3]  = '{16'h0002, 16'h0100, 16'h0100, 1'b0, 16'h0000, 1'b1};
    tv[4]  = '{16'h4003, 16'hF0F0, 16'hFF00, 1'b0, 16'hF000, 1'b1};
    tv[5]  = '{16'h5004, 16'h0F00, 16'h00F0, 1'b0, 16'h0FF0, 1'b1};
    tv[6]  = '{16'h1005, 16'hAAAA, 16'hAAAA, 1'b0, 16'h0000, 1'b0};
    tv[7]  = '{16'h0006, 16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b0};
    tv[8]  = '{16'h0016, 16'h8000, 16'h0001, 1'b0, 16'h0001, 1'b0};
    tv[9]  = '{16'h4017, 16'h8000, 16'h0001, 1'b0, 16'h8000, 1'b1};
    tv[10] = '{16'hE008, 16'h1234, 16'h5678, 1'b1, 16'h1234, 1'b1};
    tv[11] = '{16'hF008, 16'h1234, 16'h5678, 1'b0, 16'h5678, 1'b0};
    tv[12] = '{16'h0009, 16'h00AB, 16'h1111, 1'b0, 16'h00AB, 1'b0};
    tv[13] = '{16'h000A, 16'h1234, 16'h5678, 1'b0, 16'h0000, 1'b1};
    tv[14] = '{16'h8000, 16'hFFFF, 16'h0002, 1'b0, 16'h0001, 1'b1};
    tv[15] = '{16'hB010, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
    tv[16] = '{16'hC011, 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b1};
    tv[17] = '{16'h9001, 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b1};

    // Reset state
    clk_en = 1'b1;
    #12;
    check("rst_res", 32'(res), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    cfg_a = 8'hFF; #1;
    check("rst_rd_code", read_data, 32'h0);
    cfg_a = 8'hE0; #1;
    check("rst_rd_dbg", read_data, 32'h0);
    #5;
    rst_n = 1'b1;
    clk_en = 1'b0;
    cfg_a = 8'h00;
    tick();

    // Directed vector table, all operands bypassed
    for (int i = 0; i < 18; i++) begin
      cfg_write(8'hFF, {16'h0000, tv[i].op});
      data0 = tv[i].a; data1 = tv[i].b; bit0 = tv[i].d;
      clk_en = 1'b1;
      tick();
      check($sformatf("vec%0d_res", i), 32'(res), 32'(tv[i].er));
      check($sformatf("vec%0d_p", i), 32'(res_p), 32'(tv[i].ep));
      check($sformatf("vec%0d_valid", i), 32'(res_valid), 32'h1);
      clk_en = 1'b0;
    end

    // Randomized ALU ops against the reference model
    for (int i = 0; i < 30; i++) begin
      opc = {4'($urandom_range(15)), 2'b00, 1'b0, 4'b0000, 1'($urandom_range(1)), 4'($urandom_range(11))};
      ra  = ($urandom_range(3) == 0) ? 16'h7FFF : 16'($urandom);
      rb  = ($urandom_range(3) == 0) ? 16'h8000 : 16'($urandom);
      rd  = 1'($urandom_range(1));
      ref_alu(opc, ra, rb, rd, er, ep);
      cfg_write(8'hFF, {16'h0000, opc});
      data0 = ra; data1 = rb; bit0 = rd;
      clk_en = 1'b1;
      tick();
      check($sformatf("rnd%0d_res op=%0h", i, opc), 32'(res), 32'(er));
      check($sformatf("rnd%0d_p op=%0h", i, opc), 32'(res_p), 32'(ep));
      check($sformatf("rnd%0d_valid", i), 32'(res_valid), 32'h1);
      clk_en = 1'b0;
    end
    bit0 = 1'b0;
    data1 = '0;

    // Accumulate four inputs with B as constant 0
    cfg_write(8'hF1, 32'h0);
    cfg_write(8'hF8, 32'd4);
    cfg_write(8'hFF, {16'h0008, 16'h0200});
    nv = 0; rv = '0;
    for (int i = 0; i < 6; i++) begin
      data0 = (i < 4) ? 16'(i + 1) : 16'h0;
      clk_en = 1'b1;
      tick();
      if (res_valid) begin nv++; rv = res; end
      if (i == 3) begin
        cfg_a = 8'hF8; #1;
        check("acc4_cnt_readback", {24'h0, read_data[15:8]}, 32'h0);
        cfg_a = 8'hF9; #1;
        check("acc4_acc_readback", read_data, 32'h0);
        cfg_a = 8'h00;
      end
    end
    check("acc4_valid_count", 32'(nv), 32'd1);
    check("acc4_sum", 32'(rv), 32'd10);
    clk_en = 1'b0;

    // Free-running accumulation with saturation
    cfg_write(8'hF8, 32'd0);
    cfg_write(8'hFF, {16'h0008, 16'h0200});
    data0 = 16'hF000; clk_en = 1'b1;
    tick();
    check("usat_first", 32'(res), 32'hF000);
    check("usat_first_valid", 32'(res_valid), 32'h1);
    tick();
    check("usat_clamp", 32'(res), 32'hFFFF);
    check("usat_clamp_valid", 32'(res_valid), 32'h1);
    clk_en = 1'b0;
    cfg_write(8'hFF, {16'h0008, 16'h0210});
    data0 = 16'h8000; clk_en = 1'b1;
    tick();
    check("ssat_first", 32'(res), 32'h8000);
    tick();
    check("ssat_min", 32'(res), 32'h8000);
    clk_en = 1'b0;

    // Interrupt set, sticky hold, and clear
    cfg_write(8'hE0, 32'h5);
    cfg_write(8'hFF, {16'h0000, 16'h1400});
    data0 = 16'd2; data1 = 16'd3; clk_en = 1'b1;
    tick();
    check("irq_res5", 32'(res), 32'h5);
    check("irq_not_yet", 32'(irq), 32'h0);
    data0 = 16'd0; data1 = 16'd0;
    tick();
    check("irq_set", 32'(irq), 32'h1);
    clk_en = 1'b0;
    repeat (3) tick();
    check("irq_sticky", 32'(irq), 32'h1);
    cfg_a = 8'hE0; #1;
    check("irq_rd_dbg", read_data, 32'h0003_0005);
    cfg_write(8'hE0, 32'h5);
    check("irq_cleared", 32'(irq), 32'h0);
    // Set and clear landing together: clear wins
    data0 = 16'd2; data1 = 16'd3; clk_en = 1'b1;
    tick();
    data0 = 16'd0; data1 = 16'd0;
    cfg_en = 1'b1; cfg_a = 8'hE0; cfg_d = 32'h5;
    #1;
    check("irq_race_valid", 32'(res_valid), 32'h1);
    tick();
    cfg_en = 1'b0; cfg_a = 8'h00;
    check("irq_race_clear", 32'(irq), 32'h0);
    clk_en = 1'b0;

    // Stall freeze, then clearing write while advancing
    cfg_write(8'hFF, 32'h0);
    data0 = 16'd10; data1 = 16'd1; clk_en = 1'b1;
    tick();
    check("stall_pre_res", 32'(res), 32'd11);
    clk_en = 1'b0; data0 = 16'd100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_res", i), 32'(res), 32'd11);
      check($sformatf("stall%0d_valid", i), 32'(res_valid), 32'h0);
    end
    clk_en = 1'b1;
    tick();
    check("stall_resume_res", 32'(res), 32'd101);
    check("stall_resume_valid", 32'(res_valid), 32'h1);
    cfg_en = 1'b1; cfg_a = 8'hFF; cfg_d = 32'h0;
    #1;
    check("clr_same_cycle_valid", 32'(res_valid), 32'h0);
    tick();
    cfg_en = 1'b0; cfg_a = 8'h00;
    check("clr_after_valid", 32'(res_valid), 32'h0);
    tick();
    check("clr_recover_valid", 32'(res_valid), 32'h1);
    clk_en = 1'b0;

    // Async reset mid-accumulation
    cfg_write(8'hF8, 32'd4);
    cfg_write(8'hFF, {16'h0008, 16'h0200});
    data0 = 16'd1; clk_en = 1'b1;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_res", 32'(res), 32'h0);
    check("arst_valid", 32'(res_valid), 32'h0);
    cfg_a = 8'hF9; #1;
    check("arst_acc", read_data, 32'h0);
    cfg_a = 8'h00;
    #2;
    rst_n = 1'b1;
    clk_en = 1'b0;
    cfg_write(8'hF8, 32'd4);
    cfg_write(8'hFF, {16'h0008, 16'h0200});
    nv = 0; rv = '0;
    for (int i = 0; i < 6; i++) begin
      data0 = (i < 4) ? 16'd1 : 16'd0;
      clk_en = 1'b1;
      tick();
      if (res_valid) begin nv++; rv = res; end
    end
    check("arst_post_count", 32'(nv), 32'd1);
    check("arst_post_sum", 32'(rv), 32'd4);
    clk_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
